// File: rtl/scmi_db_pkg.sv
// Shared types and constants for the SCMI doorbell controller: channel state
// encoding, register offsets and per-channel strobe/status payloads.
package scmi_db_pkg;

  localparam int unsigned MAX_CHANNELS = 32;
  localparam int unsigned REG_DATA_W   = 32;

  // Byte offsets of the register map
  localparam int unsigned OFS_STATUS  = 32'h00;
  localparam int unsigned OFS_RING    = 32'h04;
  localparam int unsigned OFS_CLAIM   = 32'h08;
  localparam int unsigned OFS_DONE    = 32'h0C;
  localparam int unsigned OFS_FLAGS   = 32'h10;
  localparam int unsigned OFS_CMPL    = 32'h14;
  localparam int unsigned OFS_OVERRUN = 32'h18;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_PENDING = 2'd1,
    CH_CLAIMED = 2'd2,
    CH_DONE    = 2'd3
  } ch_state_e;

  // Decoded register-bus strobes delivered to one channel
  typedef struct packed {
    logic ring;
    logic claim;
    logic done;
    logic flag_we;
    logic flag_wd;
    logic ovr_clr;
    logic cmpl_clr;
  } ch_ctrl_t;

  // Per-channel state reported back for readback and interrupts
  typedef struct packed {
    logic busy;
    logic irq;
    logic overrun;
    logic cmpl;
    logic flag;
  } ch_stat_t;

endpackage

// File: rtl/scmi_db_channel.sv
// One SCMI doorbell channel: FSM, doorbell edge detect, overrun and completion.
// Completion tracking is built only with SCMI_DB_COMPLETION_IRQ_EN defined.
module scmi_db_channel
  import scmi_db_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  ch_ctrl_t ctrl,
  input  logic     db,
  output ch_stat_t stat
);

  ch_state_e state_q, state_d;
  logic      irq_q;
  logic      db_q;
  logic      arm_q;
  logic      ovr_q;
  logic      ovr_set;
  logic      done_entry;
  logic      db_rise;
  logic      ring;
  logic      flag_q;
  logic      cmpl_q;

  // arm_q masks the first cycle after reset so a line already high is not an edge
  assign db_rise = db & ~db_q & arm_q;
  assign ring    = ctrl.ring | db_rise;

  // Next-state and event decode
  always_comb begin
    state_d    = state_q;
    ovr_set    = 1'b0;
    done_entry = 1'b0;
    case (state_q)
      CH_IDLE: begin
        if (ring) state_d = CH_PENDING;
      end
      CH_PENDING: begin
        ovr_set = ring;
        if (ctrl.claim) state_d = CH_CLAIMED;
      end
      CH_CLAIMED: begin
        ovr_set = ring;
        // a CLAIM in the same cycle wins, and CLAIM is a no-op here
        if (ctrl.done && !ctrl.claim) begin
          state_d    = CH_DONE;
          done_entry = 1'b1;
        end
      end
      CH_DONE: begin
        ovr_set = ring;
        state_d = CH_IDLE;
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CH_IDLE;
      irq_q   <= 1'b0;
      db_q    <= 1'b0;
      arm_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= (state_d == CH_PENDING);
      db_q    <= db;
      arm_q   <= 1'b1;
      ovr_q   <= (ovr_q & ~ctrl.ovr_clr) | ovr_set;
    end
  end

`ifdef SCMI_DB_COMPLETION_IRQ_EN
  // Completion flag: set on CLAIMED->DONE when enabled; set beats clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flag_q <= 1'b0;
      cmpl_q <= 1'b0;
    end else begin
      if (ctrl.flag_we) flag_q <= ctrl.flag_wd;
      cmpl_q <= (cmpl_q & ~ctrl.cmpl_clr) | (done_entry & flag_q);
    end
  end
`else
  logic unused_cmpl;
  assign unused_cmpl = ^{ctrl.flag_we, ctrl.flag_wd, ctrl.cmpl_clr, done_entry};
  assign flag_q      = 1'b0;
  assign cmpl_q      = 1'b0;
`endif

  assign stat.busy    = (state_q != CH_IDLE);
  assign stat.irq     = irq_q;
  assign stat.overrun = ovr_q;
  assign stat.cmpl    = cmpl_q;
  assign stat.flag    = flag_q;

endmodule

// File: rtl/scmi_doorbell_ctrl.sv
// SCMI doorbell controller top: register decode/readback over NUM_CHANNELS
// channels. Optional completion IRQ selected by SCMI_DB_COMPLETION_IRQ_EN.
module scmi_doorbell_ctrl
  import scmi_db_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned ADDR_WIDTH   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    reg_valid_i,
  input  logic                    reg_we_i,
  input  logic [ADDR_WIDTH-1:0]   reg_addr_i,
  input  logic [REG_DATA_W-1:0]   reg_wdata_i,
  output logic [REG_DATA_W-1:0]   reg_rdata_o,
  output logic                    reg_rvalid_o,
  input  logic [NUM_CHANNELS-1:0] db_i,
  output logic [NUM_CHANNELS-1:0] irq_o,
  output logic [NUM_CHANNELS-1:0] cmpl_irq_o
);

  logic                    wr;
  logic                    rd;
  logic                    wr_ring;
  logic                    wr_claim;
  logic                    wr_done;
  logic                    wr_flags;
  logic                    wr_cmpl;
  logic                    wr_ovr;
  logic [NUM_CHANNELS-1:0] wbits;
  logic [NUM_CHANNELS-1:0] busy_vec;
  logic [NUM_CHANNELS-1:0] ovr_vec;
  logic [NUM_CHANNELS-1:0] cmpl_vec;
  logic [NUM_CHANNELS-1:0] flag_vec;
  logic [NUM_CHANNELS-1:0] irq_vec;
  logic [REG_DATA_W-1:0]   rdata_c;
  logic [REG_DATA_W-1:0]   rdata_q;
  logic                    rvalid_q;
  logic                    unused_wdata;

  assign wr    = reg_valid_i & reg_we_i;
  assign rd    = reg_valid_i & ~reg_we_i;
  assign wbits = reg_wdata_i[NUM_CHANNELS-1:0];

  assign unused_wdata = ^reg_wdata_i;

  // Write strobe decode; unmapped offsets fall through untouched
  assign wr_ring  = wr & (reg_addr_i == ADDR_WIDTH'(OFS_RING));
  assign wr_claim = wr & (reg_addr_i == ADDR_WIDTH'(OFS_CLAIM));
  assign wr_done  = wr & (reg_addr_i == ADDR_WIDTH'(OFS_DONE));
  assign wr_flags = wr & (reg_addr_i == ADDR_WIDTH'(OFS_FLAGS));
  assign wr_cmpl  = wr & (reg_addr_i == ADDR_WIDTH'(OFS_CMPL));
  assign wr_ovr   = wr & (reg_addr_i == ADDR_WIDTH'(OFS_OVERRUN));

  for (genvar i = 0; i < int'(NUM_CHANNELS); i++) begin : g_ch
    ch_ctrl_t ctrl;
    ch_stat_t stat;

    assign ctrl = '{
      ring:     wr_ring  & wbits[i],
      claim:    wr_claim & wbits[i],
      done:     wr_done  & wbits[i],
      flag_we:  wr_flags,
      flag_wd:  wbits[i],
      ovr_clr:  wr_ovr   & wbits[i],
      cmpl_clr: wr_cmpl  & wbits[i]
    };

    scmi_db_channel u_ch (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .ctrl   (ctrl),
      .db     (db_i[i]),
      .stat   (stat)
    );

    assign busy_vec[i] = stat.busy;
    assign ovr_vec[i]  = stat.overrun;
    assign cmpl_vec[i] = stat.cmpl;
    assign flag_vec[i] = stat.flag;
    assign irq_vec[i]  = stat.irq;
  end

  // Readback mux; channel bits above NUM_CHANNELS zero-extend
  always_comb begin
    rdata_c = '0;
    case (reg_addr_i)
      ADDR_WIDTH'(OFS_STATUS):  rdata_c = REG_DATA_W'(busy_vec);
      ADDR_WIDTH'(OFS_FLAGS):   rdata_c = REG_DATA_W'(flag_vec);
      ADDR_WIDTH'(OFS_CMPL):    rdata_c = REG_DATA_W'(cmpl_vec);
      ADDR_WIDTH'(OFS_OVERRUN): rdata_c = REG_DATA_W'(ovr_vec);
      default:                  rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd;
      if (rd) rdata_q <= rdata_c;
    end
  end

  assign reg_rdata_o  = rdata_q;
  assign reg_rvalid_o = rvalid_q;
  assign irq_o        = irq_vec;
  assign cmpl_irq_o   = cmpl_vec;

endmodule

// File: tb/tb_scmi_doorbell_ctrl.sv
// Self-checking bench for scmi_doorbell_ctrl: directed scenarios plus random
// register/doorbell traffic compared against a behavioural channel model.
module tb_scmi_doorbell_ctrl;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = 32'h0;
  logic [N-1:0] db = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic [N-1:0] irq;
  logic [N-1:0] cirq;

  logic        v32 = 1'b0;
  logic        we32 = 1'b0;
  logic [7:0]  a32 = 8'h00;
  logic [31:0] d32 = 32'h0;
  logic [31:0] db32 = 32'h0;
  logic [31:0] rdata32;
  logic        rvalid32;
  logic [31:0] irq32;
  logic [31:0] cirq32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scmi_doorbell_ctrl #(.NUM_CHANNELS(N), .ADDR_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .reg_valid_i(valid), .reg_we_i(we),
    .reg_addr_i(addr), .reg_wdata_i(wdata), .reg_rdata_o(rdata),
    .reg_rvalid_o(rvalid), .db_i(db), .irq_o(irq), .cmpl_irq_o(cirq)
  );

  scmi_doorbell_ctrl #(.NUM_CHANNELS(32), .ADDR_WIDTH(8)) dut32 (
    .clk_i(clk), .rst_ni(rst_ni), .reg_valid_i(v32), .reg_we_i(we32),
    .reg_addr_i(a32), .reg_wdata_i(d32), .reg_rdata_o(rdata32),
    .reg_rvalid_o(rvalid32), .db_i(db32), .irq_o(irq32), .cmpl_irq_o(cirq32)
  );

  // Reference model: channel lifecycle 0=idle 1=rung 2=claimed 3=done
  int          st [N];
  logic [N-1:0] m_ovr, m_flg, m_cmp, m_dbp;
  bit          m_armed;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic [N-1:0] m_irq;

`ifdef SCMI_DB_COMPLETION_IRQ_EN
  localparam bit CMPL_EN = 1'b1;
`else
  localparam bit CMPL_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < N; n++) st[n] = 0;
    m_ovr = '0; m_flg = '0; m_cmp = '0; m_dbp = '0;
    m_armed = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_irq = '0;
  endtask

  // One clock of spec behaviour, evaluated from the inputs seen at the edge
  task automatic model_step();
    bit wr, rdv, ring, claim, done;
    logic [31:0] r;
    wr  = valid && we;
    rdv = valid && !we;
    r = 32'h0;
    if (rdv) begin
      case (addr)
        8'h00: for (int n = 0; n < N; n++) r[n] = (st[n] != 0);
        8'h10: if (CMPL_EN) r = 32'(m_flg);
        8'h14: if (CMPL_EN) r = 32'(m_cmp);
        8'h18: r = 32'(m_ovr);
        default: r = 32'h0;
      endcase
      m_rdata = r;
    end
    m_rvalid = rdv;
    for (int n = 0; n < N; n++) begin
      ring  = (wr && addr == 8'h04 && wdata[n]) || (m_armed && db[n] && !m_dbp[n]);
      claim = wr && addr == 8'h08 && wdata[n];
      done  = wr && addr == 8'h0C && wdata[n];
      if (wr && addr == 8'h18 && wdata[n]) m_ovr[n] = 1'b0;
      if (CMPL_EN && wr && addr == 8'h14 && wdata[n]) m_cmp[n] = 1'b0;
      if (st[n] == 0) begin
        if (ring) st[n] = 1;
      end else begin
        if (ring) m_ovr[n] = 1'b1;
        if (st[n] == 1) begin
          if (claim) st[n] = 2;
        end else if (st[n] == 2) begin
          if (done && !claim) begin
            st[n] = 3;
            if (m_flg[n]) m_cmp[n] = 1'b1;
          end
        end else begin
          st[n] = 0;
        end
      end
      m_dbp[n] = db[n];
      m_irq[n] = (st[n] == 1);
    end
    if (CMPL_EN && wr && addr == 8'h10) m_flg = wdata[N-1:0];
    m_armed = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("irq", 32'(irq), 32'(m_irq));
    check("cmpl_irq", 32'(cirq), CMPL_EN ? 32'(m_cmp) : 32'h0);
    check("rvalid", 32'(rvalid), 32'(m_rvalid));
    if (m_rvalid) check("rdata", rdata, m_rdata);
  endtask

  task automatic idle(input int n);
    valid = 1'b0; we = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    valid = 1'b1; we = 1'b1; addr = a; wdata = d;
    cycle();
    valid = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    valid = 1'b1; we = 1'b0; addr = a;
    cycle();
    valid = 1'b0;
    check(tag, rdata, exp);
  endtask

  task automatic do_reset(input int n);
    rst_ni = 1'b0; valid = 1'b0; we = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_cirq", 32'(cirq), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0] amap [9];
    amap = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40};
    model_reset();
    #1;
    do_reset(3);

    // Ring / claim / done handshake on channel 0
    wr(8'h04, 32'h1);
    check("ring_irq0", 32'(irq[0]), 32'h1);
    rd(8'h00, 32'h1, "ring_status");
    wr(8'h08, 32'h1);
    check("claim_irq0", 32'(irq[0]), 32'h0);
    wr(8'h0C, 32'h1);
    idle(1);
    rd(8'h00, 32'h0, "done_status");

    // Doorbell lines held high: one event per channel, no overrun
    db = 8'h05;
    idle(10);
    check("db_irq", 32'(irq), 32'h05);
    rd(8'h18, 32'h0, "db_overrun");
    db = 8'h00;
    wr(8'h08, 32'h5);
    wr(8'h0C, 32'h5);
    idle(2);

    // Second ring while pending sets overrun; W1C clears it
    wr(8'h04, 32'h2);
    wr(8'h04, 32'h2);
    rd(8'h18, 32'h2, "ovr_set");
    rd(8'h00, 32'h2, "ovr_status");
    check("ovr_irq", 32'(irq), 32'h02);
    wr(8'h18, 32'h2);
    rd(8'h18, 32'h0, "ovr_clr");
    wr(8'h08, 32'h2);
    wr(8'h0C, 32'h2);
    idle(2);

    // Completion IRQ on channel 3
    wr(8'h10, 32'h8);
    wr(8'h04, 32'h8);
    wr(8'h08, 32'h8);
    wr(8'h0C, 32'h8);
    idle(3);
    check("cmpl_irq3", 32'(cirq), CMPL_EN ? 32'h8 : 32'h0);
    rd(8'h14, CMPL_EN ? 32'h8 : 32'h0, "cmpl_read");
    rd(8'h10, CMPL_EN ? 32'h8 : 32'h0, "flags_read");
    wr(8'h14, 32'h8);
    check("cmpl_w1c", 32'(cirq), 32'h0);
    rd(8'h1C, 32'h0, "unmapped");

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) db = N'($urandom);
      if ($urandom_range(0, 9) < 6) begin
        valid = 1'b1;
        we    = 1'($urandom_range(0, 1));
        addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : amap[$urandom_range(0, 8)];
        wdata = $urandom;
      end else begin
        valid = 1'b0;
        we    = 1'b0;
      end
      cycle();
    end
    valid = 1'b0; we = 1'b0;

    // Reset with channels 0 and 7 pending and a read in flight
    db = 8'h00;
    do_reset(2);
    idle(1);
    db = 8'h81;
    idle(2);
    check("pre_rst_irq", 32'(irq), 32'h81);
    valid = 1'b1; we = 1'b0; addr = 8'h00;
    #2;
    do_reset(2);
    idle(3);
    check("post_rst_irq", 32'(irq), 32'h0);
    rd(8'h00, 32'h0, "post_rst_status");
    db = 8'h00;

    // 32-channel instance: ring every channel on consecutive cycles
    check("w32_irq_init", irq32, 32'h0);
    for (int i = 0; i < 32; i++) begin
      v32 = 1'b1; we32 = 1'b1; a32 = 8'h04; d32 = 32'(1) << i;
      @(posedge clk);
      #1;
    end
    v32 = 1'b1; we32 = 1'b0; a32 = 8'h00;
    @(posedge clk);
    #1;
    v32 = 1'b0;
    check("w32_rvalid", 32'(rvalid32), 32'h1);
    check("w32_status", rdata32, 32'hFFFF_FFFF);
    check("w32_irq", irq32, 32'hFFFF_FFFF);
    check("w32_cirq", cirq32, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
